// File: rtl/vector_regfile_2r1w.sv
// Vector register file: two registered read ports, one lane-masked write port, hardware clear sweep.
// Define VRF_BYPASS_EN to forward a same-cycle write (merged word) to a matching read; otherwise read-before-write.
module vector_regfile_2r1w #(
    parameter int  LANES      = 4,
    parameter int  LANE_WIDTH = 8,
    parameter int  ADDR_WIDTH = 5,
    localparam int DATA_WIDTH = LANES * LANE_WIDTH,
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  init_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [LANES-1:0]      wr_mask,
    input  logic                  rd0_en,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic [DATA_WIDTH-1:0] rd0_data,
    output logic                  rd0_valid,
    input  logic                  rd1_en,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic                  rd1_valid
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [LANES-1:0]      mem_wmask;
    logic                  rd0_acc_p0, rd1_acc_p0;
    logic [DATA_WIDTH-1:0] rd0_word_p0, rd1_word_p0;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

`ifdef VRF_BYPASS_EN
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) res[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
        end
        return res;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // The sweep owns the write port in CLEAR; clr in RUN drops everything sampled with it.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        mem_we     = 1'b0;
        mem_waddr  = ptr;
        mem_wdata  = '0;
        mem_wmask  = '1;
        rd0_acc_p0 = 1'b0;
        rd1_acc_p0 = 1'b0;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                if (clr) begin
                    ptr_nxt = '0;
                end else if (ptr == '1) begin
                    state_nxt = RUN;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + ADDR_WIDTH'(1);
                end
            end
            RUN: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end else begin
                    mem_we     = wr_en;
                    mem_waddr  = wr_addr;
                    mem_wdata  = wr_data;
                    mem_wmask  = wr_mask;
                    rd0_acc_p0 = rd0_en;
                    rd1_acc_p0 = rd1_en;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign init_busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_wmask[i])
                    mem[mem_waddr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_comb begin
        rd0_word_p0 = mem[rd0_addr];
        rd1_word_p0 = mem[rd1_addr];
`ifdef VRF_BYPASS_EN
        if (mem_we && (mem_waddr == rd0_addr))
            rd0_word_p0 = merge_lanes(mem[rd0_addr], mem_wdata, mem_wmask);
        if (mem_we && (mem_waddr == rd1_addr))
            rd1_word_p0 = merge_lanes(mem[rd1_addr], mem_wdata, mem_wmask);
`endif
    end

    // Read stage: data holds when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_data  <= '0;
            rd0_valid <= 1'b0;
            rd1_data  <= '0;
            rd1_valid <= 1'b0;
        end else begin
            rd0_valid <= rd0_acc_p0;
            rd1_valid <= rd1_acc_p0;
            if (rd0_acc_p0) rd0_data <= rd0_word_p0;
            if (rd1_acc_p0) rd1_data <= rd1_word_p0;
        end
    end

endmodule

// File: tb/tb_vector_regfile_2r1w.sv
// Directed self-checking bench for vector_regfile_2r1w (default parameters, RAM_DEPTH = 32).
module tb_vector_regfile_2r1w;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          init_busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_mask;
    logic          rd0_en;
    logic [AW-1:0] rd0_addr;
    logic [DW-1:0] rd0_data;
    logic          rd0_valid;
    logic          rd1_en;
    logic [AW-1:0] rd1_addr;
    logic [DW-1:0] rd1_data;
    logic          rd1_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vector_regfile_2r1w dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .init_busy (init_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .rd0_en    (rd0_en),
        .rd0_addr  (rd0_addr),
        .rd0_data  (rd0_data),
        .rd0_valid (rd0_valid),
        .rd1_en    (rd1_en),
        .rd1_addr  (rd1_addr),
        .rd1_data  (rd1_data),
        .rd1_valid (rd1_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read0(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
        rd0_en = 1'b1; rd0_addr = a;
        tick();
        rd0_en = 1'b0;
        d = rd0_data; v = rd0_valid;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (init_busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd0_en = 1'b0; rd0_addr = '0; rd1_en = 1'b0; rd1_addr = '0;
        tick(); tick();
        total_cnt++;
        if ({init_busy, rd0_valid, rd1_valid} !== 3'b100) $display("FAIL reset_ctrl: got busy/v0/v1=%b expected 100", {init_busy, rd0_valid, rd1_valid});
        else pass_cnt++;
        total_cnt++;
        if (rd0_data !== 32'h0 || rd1_data !== 32'h0) $display("FAIL reset_data: got %h/%h expected 0/0", rd0_data, rd1_data);
        else pass_cnt++;
        rst_n = 1'b1;
        wait_sweep(n);
        total_cnt++;
        if (n !== 32) $display("FAIL reset_sweep_len: got %0d cycles expected 32", n);
        else pass_cnt++;
        for (int a = 0; a < 32; a++) begin
            rd0_en = 1'b1; rd0_addr = AW'(a); rd1_en = 1'b1; rd1_addr = AW'(31 - a);
            tick();
            total_cnt++;
            if (rd0_valid !== 1'b1 || rd0_data !== 32'h0) $display("FAIL sweep_read0[%0d]: got v=%b d=%h expected v=1 d=00000000", a, rd0_valid, rd0_data);
            else pass_cnt++;
            total_cnt++;
            if (rd1_valid !== 1'b1 || rd1_data !== 32'h0) $display("FAIL sweep_read1[%0d]: got v=%b d=%h expected v=1 d=00000000", 31 - a, rd1_valid, rd1_data);
            else pass_cnt++;
        end
        rd0_en = 1'b0; rd1_en = 1'b0;
        tick();
        total_cnt++;
        if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) $display("FAIL idle_valid: got %b%b expected 00", rd0_valid, rd1_valid);
        else pass_cnt++;
    endtask

    task automatic test_lane_mask();
        logic [DW-1:0] d;
        logic          v;
        do_write(3, 32'hAABBCCDD, 4'b1111);
        do_write(3, 32'h11223344, 4'b0101);
        read0(3, d, v);
        total_cnt++;
        if (v !== 1'b1 || d !== 32'hAA22CC44) $display("FAIL lane_mask: got v=%b d=%h expected v=1 d=aa22cc44", v, d);
        else pass_cnt++;
        do_write(3, 32'hFFFFFFFF, 4'b0000);
        read0(3, d, v);
        total_cnt++;
        if (v !== 1'b1 || d !== 32'hAA22CC44) $display("FAIL mask_zero_noop: got v=%b d=%h expected v=1 d=aa22cc44", v, d);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] exp0;
        logic [DW-1:0] d;
        logic          v;
`ifdef VRF_BYPASS_EN
        exp0 = 32'h12345678;
`else
        exp0 = 32'h00000000;
`endif
        do_write(8, 32'hCAFEF00D, 4'b1111);
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h12345678; wr_mask = 4'b1111;
        rd0_en = 1'b1; rd0_addr = 7; rd1_en = 1'b1; rd1_addr = 8;
        tick();
        wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
        total_cnt++;
        if (rd0_valid !== 1'b1 || rd0_data !== exp0) $display("FAIL same_cycle_port0: got v=%b d=%h expected v=1 d=%h", rd0_valid, rd0_data, exp0);
        else pass_cnt++;
        total_cnt++;
        if (rd1_valid !== 1'b1 || rd1_data !== 32'hCAFEF00D) $display("FAIL same_cycle_port1: got v=%b d=%h expected v=1 d=cafef00d", rd1_valid, rd1_data);
        else pass_cnt++;
        read0(7, d, v);
        total_cnt++;
        if (v !== 1'b1 || d !== 32'h12345678) $display("FAIL write_visible_next: got v=%b d=%h expected v=1 d=12345678", v, d);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        logic [DW-1:0] d;
        logic          v;
        int            n;
        for (int a = 0; a < 32; a++) do_write(AW'(a), 32'h01010101 * a, 4'b1111);
        read0(5, d, v);
        total_cnt++;
        if (v !== 1'b1 || d !== 32'h05050505) $display("FAIL fill_addr5: got v=%b d=%h expected v=1 d=05050505", v, d);
        else pass_cnt++;
        read0(31, d, v);
        total_cnt++;
        if (v !== 1'b1 || d !== 32'h1F1F1F1F) $display("FAIL fill_addr31: got v=%b d=%h expected v=1 d=1f1f1f1f", v, d);
        else pass_cnt++;
        clr = 1'b1; wr_en = 1'b1; wr_addr = 5; wr_data = 32'hFFFFFFFF; wr_mask = 4'b1111;
        rd0_en = 1'b1; rd0_addr = 5; rd1_en = 1'b1; rd1_addr = 9;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        total_cnt++;
        if ({init_busy, rd0_valid, rd1_valid} !== 3'b100) $display("FAIL clr_accept: got busy/v0/v1=%b expected 100", {init_busy, rd0_valid, rd1_valid});
        else pass_cnt++;
        total_cnt++;
        if (rd0_data !== 32'h1F1F1F1F) $display("FAIL clr_hold_data: got %h expected 1f1f1f1f", rd0_data);
        else pass_cnt++;
        n = 0;
        while (init_busy && n < 100) begin
            tick();
            n++;
            total_cnt++;
            if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) $display("FAIL sweep_read_ignored[%0d]: got %b%b expected 00", n, rd0_valid, rd1_valid);
            else pass_cnt++;
        end
        rd0_en = 1'b0; rd1_en = 1'b0;
        total_cnt++;
        if (n !== 32) $display("FAIL clr_sweep_len: got %0d cycles expected 32", n);
        else pass_cnt++;
        for (int a = 0; a < 32; a++) begin
            rd0_en = 1'b1; rd0_addr = AW'(a); rd1_en = 1'b1; rd1_addr = AW'(a ^ 5);
            tick();
            total_cnt++;
            if (rd0_valid !== 1'b1 || rd0_data !== 32'h0 || rd1_valid !== 1'b1 || rd1_data !== 32'h0)
                $display("FAIL cleared[%0d]: got v=%b%b d=%h/%h expected v=11 d=0/0", a, rd0_valid, rd1_valid, rd0_data, rd1_data);
            else pass_cnt++;
        end
        rd0_en = 1'b0; rd1_en = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        logic [DW-1:0] d;
        logic          v;
        int            n;
        do_write(2, 32'h00000055, 4'b1111);
        read0(2, d, v);
        rd1_en = 1'b1; rd1_addr = 2;
        tick();
        rd1_en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({init_busy, rd0_valid, rd1_valid} !== 3'b100 || rd0_data !== 32'h0 || rd1_data !== 32'h0)
            $display("FAIL mid_reset_values: got busy/v=%b d=%h/%h expected 100 d=0/0", {init_busy, rd0_valid, rd1_valid}, rd0_data, rd1_data);
        else pass_cnt++;
        tick(); tick(); tick();
        rst_n = 1'b1;
        wait_sweep(n);
        total_cnt++;
        if (n !== 32) $display("FAIL mid_reset_sweep_len: got %0d cycles expected 32", n);
        else pass_cnt++;
        read0(2, d, v);
        total_cnt++;
        if (v !== 1'b1 || d !== 32'h0) $display("FAIL mid_reset_cleared: got v=%b d=%h expected v=1 d=00000000", v, d);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] pat [16];
        for (int a = 0; a < 16; a++) begin
            pat[a] = {8'(a), 8'(~a), 8'(a + 16), 8'hC3};
            do_write(AW'(a), pat[a], 4'b1111);
        end
        for (int a = 0; a < 16; a++) begin
            rd0_en = 1'b1; rd0_addr = AW'(a); rd1_en = 1'b1; rd1_addr = AW'(15 - a);
            tick();
            total_cnt++;
            if (rd0_valid !== 1'b1 || rd0_data !== pat[a]) $display("FAIL b2b_port0[%0d]: got v=%b d=%h expected v=1 d=%h", a, rd0_valid, rd0_data, pat[a]);
            else pass_cnt++;
            total_cnt++;
            if (rd1_valid !== 1'b1 || rd1_data !== pat[15 - a]) $display("FAIL b2b_port1[%0d]: got v=%b d=%h expected v=1 d=%h", 15 - a, rd1_valid, rd1_data, pat[15 - a]);
            else pass_cnt++;
        end
        rd0_en = 1'b0; rd1_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0 || rd0_data !== pat[15] || rd1_data !== pat[0])
                $display("FAIL b2b_hold[%0d]: got v=%b%b d=%h/%h expected v=00 d=%h/%h", i, rd0_valid, rd1_valid, rd0_data, rd1_data, pat[15], pat[0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_lane_mask();
        test_same_cycle();
        test_clear();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
